// File: rtl/bscn_pkg.sv
// Shared constants and strobe decode for the boundary-scan output bank.
// Chain layout: cell index = channel * CELLS_PER_CH + offset, channel 0 nearest TDO.
package bscn_pkg;

  localparam int unsigned EN_OFS       = 0;
  localparam int unsigned DAT_OFS      = 1;
  localparam int unsigned CELLS_PER_CH = 2;

  typedef enum logic [1:0] {
    STB_HOLD    = 2'd0,
    STB_CAPTURE = 2'd1,
    STB_SHIFT   = 2'd2
  } strobe_e;

  function automatic int unsigned cell_idx(input int unsigned ch, input int unsigned ofs);
    return ch * CELLS_PER_CH + ofs;
  endfunction

  // CAPTURE outranks SHIFT; UPDATE is handled independently of this decode.
  function automatic strobe_e strobe_sel(input logic capture, input logic shift);
    strobe_e op;
    op = STB_HOLD;
    if (capture)
      op = STB_CAPTURE;
    else if (shift)
      op = STB_SHIFT;
    return op;
  endfunction

endpackage

// File: rtl/bscn_cell.sv
// One boundary-scan output cell: capture/shift flop, update flop and
// functional/test output mux.
module bscn_cell
  import bscn_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic    ck,
  input  logic    rst,
  input  strobe_e op,
  input  logic    core,
  input  logic    ser_in,
  input  logic    upd,
  input  logic    mode,
  output logic    ser_out,
  output logic    pad
);

  logic sr_q;
  logic ur_q;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      sr_q <= 1'b0;
    end else begin
      case (op)
        STB_CAPTURE: sr_q <= core;
        STB_SHIFT:   sr_q <= ser_in;
        default:     sr_q <= sr_q;
      endcase
    end
  end

  // Update samples the pre-edge shift value, so a concurrent shift is invisible here.
  always_ff @(posedge ck or posedge rst) begin
    if (rst)
      ur_q <= RST_VAL;
    else if (upd)
      ur_q <= sr_q;
  end

  assign ser_out = sr_q;
  assign pad     = mode ? ur_q : core;

endmodule

// File: rtl/bscn_out_bank.sv
// Boundary-scan output bank: WIDTH channels, 2*WIDTH-cell chain (enable cell then data cell).
// Optional 1-bit bypass path when BSCN_BYPASS_EN is defined.
module bscn_out_bank
  import bscn_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic        RST_DATA = 1'b0
) (
  input  logic             CK,
  input  logic             RST,
`ifdef BSCN_BYPASS_EN
  input  logic             BYPASS,
`endif
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] OE,
  input  logic             MODE,
  input  logic             CAPTURE,
  input  logic             SHIFT,
  input  logic             UPDATE,
  input  logic             TDI,
  output logic             TDO,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] X_OE
);

  localparam int unsigned CHAIN = CELLS_PER_CH * WIDTH;

  logic [CHAIN-1:0] sr;
  logic [CHAIN-1:0] chain_in;
  logic             bypass_sel;
  logic             upd_en;
  strobe_e          op;

  // Each cell loads from its TDI-side neighbour; the last cell takes TDI directly.
  assign chain_in = {TDI, sr[CHAIN-1:1]};

  always_comb begin
    op = STB_HOLD;
    if (!bypass_sel)
      op = strobe_sel(CAPTURE, SHIFT);
  end

  assign upd_en = UPDATE & ~bypass_sel;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    localparam int unsigned EI = cell_idx(i, EN_OFS);
    localparam int unsigned DI = cell_idx(i, DAT_OFS);

    bscn_cell #(.RST_VAL(1'b0)) u_en (
      .ck      (CK),
      .rst     (RST),
      .op      (op),
      .core    (OE[i]),
      .ser_in  (chain_in[EI]),
      .upd     (upd_en),
      .mode    (MODE),
      .ser_out (sr[EI]),
      .pad     (X_OE[i])
    );

    bscn_cell #(.RST_VAL(RST_DATA)) u_dat (
      .ck      (CK),
      .rst     (RST),
      .op      (op),
      .core    (D[i]),
      .ser_in  (chain_in[DI]),
      .upd     (upd_en),
      .mode    (MODE),
      .ser_out (sr[DI]),
      .pad     (X[i])
    );
  end

`ifdef BSCN_BYPASS_EN
  logic byp_q;

  assign bypass_sel = BYPASS;

  always_ff @(posedge CK or posedge RST) begin
    if (RST)
      byp_q <= 1'b0;
    else if (BYPASS) begin
      if (CAPTURE)
        byp_q <= 1'b0;
      else if (SHIFT)
        byp_q <= TDI;
    end
  end

  assign TDO = BYPASS ? byp_q : sr[0];
`else
  assign bypass_sel = 1'b0;
  assign TDO        = sr[0];
`endif

endmodule

// File: tb/tb_bscn_out_bank.sv
// Directed bench for bscn_out_bank at WIDTH=4, RST_DATA=0.
// Bypass vectors are compiled in only when BSCN_BYPASS_EN is defined.
module tb_bscn_out_bank;

  localparam int unsigned W = 4;

  logic         CK = 1'b0;
  logic         RST;
  logic [W-1:0] D;
  logic [W-1:0] OE;
  logic         MODE;
  logic         CAPTURE;
  logic         SHIFT;
  logic         UPDATE;
  logic         TDI;
  logic         TDO;
  logic [W-1:0] X;
  logic [W-1:0] X_OE;
`ifdef BSCN_BYPASS_EN
  logic         BYPASS = 1'b0;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 CK = ~CK;

  bscn_out_bank #(.WIDTH(W), .RST_DATA(1'b0)) dut (
    .CK      (CK),
    .RST     (RST),
`ifdef BSCN_BYPASS_EN
    .BYPASS  (BYPASS),
`endif
    .D       (D),
    .OE      (OE),
    .MODE    (MODE),
    .CAPTURE (CAPTURE),
    .SHIFT   (SHIFT),
    .UPDATE  (UPDATE),
    .TDI     (TDI),
    .TDO     (TDO),
    .X       (X),
    .X_OE    (X_OE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic shift_in(input logic [7:0] pat);
    for (int k = 0; k < 8; k++) begin
      TDI   = pat[k];
      SHIFT = 1'b1;
      tick();
    end
    SHIFT = 1'b0;
    TDI   = 1'b0;
  endtask

  task automatic pulse_update();
    UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq;

    RST = 1'b1; D = '0; OE = '0; MODE = 1'b1;
    CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0; TDI = 1'b0;
    tick();

    // Reset state in test mode
    check("rst_x_oe", {28'd0, X_OE}, 32'h0);
    check("rst_x",    {28'd0, X},    32'h0);
    check("rst_tdo",  {31'd0, TDO},  32'h0);

    // Functional path during reset
    MODE = 1'b0; D = 4'h5; OE = 4'h3; #1;
    check("rst_func_x",    {28'd0, X},    32'h5);
    check("rst_func_x_oe", {28'd0, X_OE}, 32'h3);
    MODE = 1'b1;
    tick();
    RST = 1'b0;
    tick();

    // Capture D=A, OE=F, then observe chain at TDO
    D = 4'hA; OE = 4'hF; CAPTURE = 1'b1;
    tick();
    CAPTURE = 1'b0;
    seq = 8'b1101_1101;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("cap_tdo_%0d", k), {31'd0, TDO}, {31'd0, seq[k]});
      SHIFT = 1'b1;
      tick();
    end
    SHIFT = 1'b0;
    check("shift_no_x_oe", {28'd0, X_OE}, 32'h0);

    // Shift in F5, update: enables 1111, data bits 1,3,5,7 = 0,0,1,1
    shift_in(8'hF5);
    check("pre_upd_x_oe", {28'd0, X_OE}, 32'h0);
    pulse_update();
    check("upd_x_oe", {28'd0, X_OE}, 32'hF);
    check("upd_x",    {28'd0, X},    32'hC);
    D = 4'h3; OE = 4'h0; #1;
    check("hold_x_oe", {28'd0, X_OE}, 32'hF);
    check("hold_x",    {28'd0, X},    32'hC);
    MODE = 1'b0; #1;
    check("mode0_x",    {28'd0, X},    32'h3);
    check("mode0_x_oe", {28'd0, X_OE}, 32'h0);
    MODE = 1'b1; #1;
    check("mode1_x",    {28'd0, X},    32'hC);
    shift_in(8'h00);
    check("shift_keep_x",    {28'd0, X},    32'hC);
    check("shift_keep_x_oe", {28'd0, X_OE}, 32'hF);

    // CAPTURE and SHIFT together: capture of D=3, OE=5 gives chain 1B
    D = 4'h3; OE = 4'h5; CAPTURE = 1'b1; SHIFT = 1'b1;
    tick();
    CAPTURE = 1'b0; SHIFT = 1'b0;
    check("prio_tdo", {31'd0, TDO}, 32'h1);
    pulse_update();
    check("prio_x_oe", {28'd0, X_OE}, 32'h5);
    check("prio_x",    {28'd0, X},    32'h3);

    // UPDATE with SHIFT: update keeps 1B, chain becomes 8D
    D = 4'h0; OE = 4'h0;
    SHIFT = 1'b1; UPDATE = 1'b1; TDI = 1'b1;
    tick();
    SHIFT = 1'b0; UPDATE = 1'b0; TDI = 1'b0;
    check("us_x_oe", {28'd0, X_OE}, 32'h5);
    check("us_x",    {28'd0, X},    32'h3);
    check("us_tdo",  {31'd0, TDO},  32'h1);
    pulse_update();
    check("us2_x_oe", {28'd0, X_OE}, 32'h3);
    check("us2_x",    {28'd0, X},    32'hA);

    // Three shifts of 1 into 8D give F1, then reset mid-shift
    SHIFT = 1'b1; TDI = 1'b1;
    tick(); tick(); tick();
    check("mid_tdo", {31'd0, TDO}, 32'h1);
    RST = 1'b1; #1;
    check("mid_rst_tdo",  {31'd0, TDO},  32'h0);
    check("mid_rst_x_oe", {28'd0, X_OE}, 32'h0);
    check("mid_rst_x",    {28'd0, X},    32'h0);
    SHIFT = 1'b0; TDI = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    check("post_rst_tdo", {31'd0, TDO}, 32'h0);
    shift_in(8'h96);
    check("post_tdo",     {31'd0, TDO},  32'h0);
    check("post_x_oe_0",  {28'd0, X_OE}, 32'h0);
    pulse_update();
    check("post_x_oe", {28'd0, X_OE}, 32'h6);
    check("post_x",    {28'd0, X},    32'h9);

`ifdef BSCN_BYPASS_EN
    BYPASS = 1'b1; D = 4'hF; OE = 4'hF; CAPTURE = 1'b1;
    tick();
    CAPTURE = 1'b0;
    check("byp_cap_tdo", {31'd0, TDO}, 32'h0);
    TDI = 1'b1; SHIFT = 1'b1; tick();
    check("byp_tdo_0", {31'd0, TDO}, 32'h1);
    TDI = 1'b0; tick();
    check("byp_tdo_1", {31'd0, TDO}, 32'h0);
    TDI = 1'b1; tick();
    check("byp_tdo_2", {31'd0, TDO}, 32'h1);
    SHIFT = 1'b0; TDI = 1'b0;
    CAPTURE = 1'b1; UPDATE = 1'b1;
    tick();
    CAPTURE = 1'b0; UPDATE = 1'b0;
    check("byp_upd_x", {28'd0, X}, 32'h9);
    BYPASS = 1'b0; #1;
    check("byp_main_tdo", {31'd0, TDO}, 32'h0);
    pulse_update();
    check("byp_main_x_oe", {28'd0, X_OE}, 32'h6);
    check("byp_main_x",    {28'd0, X},    32'h9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
